multdiv_scheduler: RTL and testbench

Issue and writeback controller for the shared iterative multiply/divide unit. It accepts one mult/div from the execute stage and pulses the unit's start controls. It tracks the pending destination register and stalls the front end only on structural or register hazards. It buffers the result and injects it into the register-file write port when the main pipeline's memory/writeback stage is not writing.

---
 rtl/multdiv_scheduler.sv | 128 ++++++++++++
 tb/tb_multdiv_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_scheduler.sv
// rtl/multdiv_scheduler.sv - issue/writeback controller for the shared iterative multiply/divide unit
// Optional feature: MD_EXCEPTION_EN (redirect excepting results to r30 with a cause code)
module multdiv_scheduler #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic              issue_is_div,
  input  logic [REG_W-1:0]  issue_rd,
  output logic              issue_ready,
  input  logic [REG_W-1:0]  dec_rs,
  input  logic [REG_W-1:0]  dec_rt,
  input  logic [REG_W-1:0]  dec_rd,
  input  logic              dec_uses_rd,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_ready,
  input  logic              pipe_wb_valid,
  output logic              pipe_stall,
  output logic              wb_sel,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  typedef enum logic [1:0] {IDLE, BUSY, PEND} state_t;

  localparam logic [REG_W-1:0] EXC_RD = REG_W'(30);

  state_t              state, state_nxt;
  logic [REG_W-1:0]    pend_rd;
  logic                pend_is_div;
  logic [DATA_W-1:0]   buf_data;
  logic                buf_exc;
  logic                capture_issue, capture_result;
  logic [REG_W-1:0]    eff_rd;
  logic [DATA_W-1:0]   eff_data;
  logic                hazard_rd, hazard_exc;
  logic                active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend_rd     <= '0;
      pend_is_div <= 1'b0;
      buf_data    <= '0;
      buf_exc     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture_issue) begin
        pend_rd     <= issue_rd;
        pend_is_div <= issue_is_div;
      end
      if (capture_result) begin
        buf_data <= md_result;
        buf_exc  <= md_exception;
      end
    end
  end

`ifdef MD_EXCEPTION_EN
  // Cause code: 4 = mult overflow, 5 = divide fault. r30 is guarded for the whole op
  // because the exception is only known once the result arrives.
  assign eff_rd     = buf_exc ? EXC_RD : pend_rd;
  assign eff_data   = buf_exc ? (pend_is_div ? DATA_W'(5) : DATA_W'(4)) : buf_data;
  assign hazard_exc = (dec_rs == EXC_RD) || (dec_rt == EXC_RD) ||
                      (dec_uses_rd && (dec_rd == EXC_RD));
`else
  logic unused_exc;
  assign unused_exc = buf_exc;
  assign eff_rd     = pend_rd;
  assign eff_data   = buf_data;
  assign hazard_exc = 1'b0;
`endif

  assign active    = (state != IDLE);
  assign hazard_rd = (pend_rd != '0) &&
                     ((dec_rs == pend_rd) || (dec_rt == pend_rd) ||
                      (dec_uses_rd && (dec_rd == pend_rd)));

  always_comb begin
    state_nxt      = state;
    issue_ready    = 1'b0;
    md_ctrl_mult   = 1'b0;
    md_ctrl_div    = 1'b0;
    capture_issue  = 1'b0;
    capture_result = 1'b0;
    wb_sel         = 1'b0;
    case (state)
      IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid && rst_n) begin
          capture_issue = 1'b1;
          md_ctrl_div   = issue_is_div;
          md_ctrl_mult  = !issue_is_div;
          state_nxt     = BUSY;
        end
      end
      BUSY: begin
        if (md_ready) begin
          capture_result = 1'b1;
          state_nxt      = PEND;
        end
      end
      PEND: begin
        // r0 is never written; the pipeline always has priority on the port.
        if (eff_rd == '0) begin
          state_nxt = IDLE;
        end else if (!pipe_wb_valid) begin
          wb_sel    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pipe_stall = (active && issue_valid) ||
                      (active && (hazard_rd || hazard_exc)) ||
                      (state == PEND);

  assign wb_rd   = (state == PEND) ? eff_rd   : '0;
  assign wb_data = (state == PEND) ? eff_data : '0;

endmodule

// File: tb/tb_multdiv_scheduler.sv
// tb/tb_multdiv_scheduler.sv - self-checking bench for multdiv_scheduler
module tb_multdiv_scheduler;

  logic        clk;
  logic        rst_n;
  logic        issue_valid, issue_is_div, issue_ready;
  logic [4:0]  issue_rd, dec_rs, dec_rt, dec_rd;
  logic        dec_uses_rd;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_result;
  logic        md_exception, md_ready, pipe_wb_valid;
  logic        pipe_stall, wb_sel;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  multdiv_scheduler #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_rd(issue_rd),
    .issue_ready(issue_ready),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd), .dec_uses_rd(dec_uses_rd),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
    .pipe_wb_valid(pipe_wb_valid), .pipe_stall(pipe_stall),
    .wb_sel(wb_sel), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_div;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        exc;
    int          lat;
    int          conflict;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } sb_t;

  vec_t vecs[6];
  sb_t  exp_q[$];
  sb_t  mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data);
    sb_t s;
    s.rd   = rd;
    s.data = data;
    exp_q.push_back(s);
  endtask

  // Writeback monitor: every scheduler write must match the oldest expectation.
  always begin
    @(negedge clk);
    #3;
    if (rst_n && wb_sel) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected actual rd=%0d data=%0h required none", wb_rd, wb_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_wb_rd", 32'(wb_rd), 32'(mon_e.rd));
        chk("sb_wb_data", wb_data, mon_e.data);
      end
    end
  end

  task automatic run_op(input vec_t v);
    tick();
    issue_valid = 1'b1; issue_is_div = v.is_div; issue_rd = v.rd;
    #1;
    chk("issue_ready_idle", 32'(issue_ready), 32'd1);
    chk("md_ctrl_mult_pulse", 32'(md_ctrl_mult), 32'(!v.is_div));
    chk("md_ctrl_div_pulse", 32'(md_ctrl_div), 32'(v.is_div));
    if (v.exp_rd != 5'd0) expect_wb(v.exp_rd, v.exp_data);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("md_ctrl_mult_off", 32'(md_ctrl_mult), 32'd0);
    chk("md_ctrl_div_off", 32'(md_ctrl_div), 32'd0);
    chk("issue_ready_busy", 32'(issue_ready), 32'd0);
    chk("wb_rd_busy", 32'(wb_rd), 32'd0);
    repeat (v.lat - 1) tick();
    tick();
    md_ready = 1'b1; md_result = v.res; md_exception = v.exc;
    pipe_wb_valid = (v.conflict > 0);
    #1 chk("wb_sel_at_ready", 32'(wb_sel), 32'd0);
    for (int i = 0; i < v.conflict; i++) begin
      tick();
      md_ready = 1'b0; pipe_wb_valid = 1'b1;
      #1 chk("wb_sel_blocked", 32'(wb_sel), 32'd0);
    end
    tick();
    md_ready = 1'b0; pipe_wb_valid = 1'b0; md_exception = 1'b0;
    #1;
    chk("wb_sel_retire", 32'(wb_sel), 32'(v.exp_rd != 5'd0));
    chk("pipe_stall_pend", 32'(pipe_stall), 32'd1);
    tick();
    #1;
    chk("issue_ready_after", 32'(issue_ready), 32'd1);
    chk("wb_sel_after", 32'(wb_sel), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 5'd3,  32'd42,         1'b0, 33, 0, 5'd3,  32'd42};
    vecs[1] = '{1'b1, 5'd7,  32'hdead_beef,  1'b0, 5,  2, 5'd7,  32'hdead_beef};
    vecs[2] = '{1'b0, 5'd0,  32'd99,         1'b0, 3,  0, 5'd0,  32'd0};
    vecs[3] = '{1'b0, 5'd31, 32'hffff_ffff,  1'b0, 1,  0, 5'd31, 32'hffff_ffff};
`ifdef MD_EXCEPTION_EN
    vecs[4] = '{1'b1, 5'd9,  32'd123,        1'b1, 4,  0, 5'd30, 32'd5};
    vecs[5] = '{1'b0, 5'd12, 32'd77,         1'b1, 2,  1, 5'd30, 32'd4};
`else
    vecs[4] = '{1'b1, 5'd9,  32'd123,        1'b1, 4,  0, 5'd9,  32'd123};
    vecs[5] = '{1'b0, 5'd12, 32'd77,         1'b1, 2,  1, 5'd12, 32'd77};
`endif

    rst_n = 1'b0;
    issue_valid = 0; issue_is_div = 0; issue_rd = 0;
    dec_rs = 0; dec_rt = 0; dec_rd = 0; dec_uses_rd = 0;
    md_result = 0; md_exception = 0; md_ready = 0; pipe_wb_valid = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_pipe_stall", 32'(pipe_stall), 32'd0);
    chk("rst_wb_sel", 32'(wb_sel), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);

    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    // RAW/WAW hazard against pending rd=5
    tick();
    issue_valid = 1; issue_is_div = 0; issue_rd = 5'd5;
    expect_wb(5'd5, 32'h55);
    tick();
    issue_valid = 0;
    dec_rs = 5'd5; #1 chk("raw_rs", 32'(pipe_stall), 32'd1);
    tick(); dec_rs = 5'd6; #1 chk("raw_rs_indep", 32'(pipe_stall), 32'd0);
    tick(); dec_rt = 5'd5; #1 chk("raw_rt", 32'(pipe_stall), 32'd1);
    tick(); dec_rt = 5'd0; dec_rd = 5'd5; dec_uses_rd = 0; #1 chk("waw_rd_unused", 32'(pipe_stall), 32'd0);
    tick(); dec_uses_rd = 1; #1 chk("waw_rd", 32'(pipe_stall), 32'd1);
    tick(); dec_rd = 5'd0; dec_uses_rd = 0; dec_rs = 5'd5;
    md_ready = 1; md_result = 32'h55;
    #1 chk("raw_at_ready", 32'(pipe_stall), 32'd1);
    tick(); md_ready = 0;
    #1 chk("raw_wb_cycle_sel", 32'(wb_sel), 32'd1);
    chk("raw_wb_cycle_stall", 32'(pipe_stall), 32'd1);
    tick();
    #1 chk("raw_cleared", 32'(pipe_stall), 32'd0);
    dec_rs = 0;

    // Structural: second issue held while busy
    tick();
    issue_valid = 1; issue_is_div = 1; issue_rd = 5'd4;
    expect_wb(5'd4, 32'h444);
    #1 chk("struct_first_div", 32'(md_ctrl_div), 32'd1);
    tick();
    issue_is_div = 0; issue_rd = 5'd8;
    #1;
    chk("struct_ready", 32'(issue_ready), 32'd0);
    chk("struct_stall", 32'(pipe_stall), 32'd1);
    chk("struct_no_mult", 32'(md_ctrl_mult), 32'd0);
    tick(); md_ready = 1; md_result = 32'h444;
    tick(); md_ready = 0;
    #1;
    chk("struct_retire_sel", 32'(wb_sel), 32'd1);
    chk("struct_retire_refused", 32'(issue_ready), 32'd0);
    chk("struct_retire_no_mult", 32'(md_ctrl_mult), 32'd0);
    tick();
    #1;
    chk("struct_accept_ready", 32'(issue_ready), 32'd1);
    chk("struct_accept_mult", 32'(md_ctrl_mult), 32'd1);
    expect_wb(5'd8, 32'h888);
    tick(); issue_valid = 0;
    tick(); md_ready = 1; md_result = 32'h888;
    tick(); md_ready = 0;
    #1 chk("struct_second_sel", 32'(wb_sel), 32'd1);
    tick();

    // Reset while busy discards the op
    tick();
    issue_valid = 1; issue_is_div = 0; issue_rd = 5'd6;
    tick(); issue_valid = 0;
    tick(); rst_n = 0; issue_valid = 1;
    #1;
    chk("rstb_md_ctrl_mult", 32'(md_ctrl_mult), 32'd0);
    chk("rstb_pipe_stall", 32'(pipe_stall), 32'd0);
    chk("rstb_wb_sel", 32'(wb_sel), 32'd0);
    chk("rstb_wb_data", wb_data, 32'd0);
    tick(); issue_valid = 0; rst_n = 1;
    tick(); md_ready = 1; md_result = 32'h77;
    #1 chk("rstb_ready_ignored", 32'(issue_ready), 32'd1);
    tick(); md_ready = 0;
    #1;
    chk("rstb_no_wb", 32'(wb_sel), 32'd0);
    chk("rstb_wb_rd", 32'(wb_rd), 32'd0);
    chk("rstb_issue_ready", 32'(issue_ready), 32'd1);
    repeat (2) tick();

    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
